id_entry_handler: RTL and testbench



---
 rtl/id_entry_handler_pkg.sv | 25 ++
 rtl/id_entry_handler_if.sv | 26 ++
 rtl/id_entry_handler.sv | 129 ++++++++++++
 tb/tb_id_entry_handler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/id_entry_handler_pkg.sv
// Shared definitions for the login front end: state encoding, ROM geometry
// and the empty-slot marker. The password stage imports this for its
// player-address width.
package id_entry_handler_pkg;

  localparam int NUM_USERS = 8;
  localparam int ID_WIDTH  = 16;
  localparam int ADDR_W    = $clog2(NUM_USERS);
  localparam int DCNT_W    = 3;

  localparam logic [ID_WIDTH-1:0] EMPTY_ID = 16'hFFFF;

  typedef enum logic [3:0] {
    ST_STANDBY   = 4'd0,
    ST_DIGIT2    = 4'd1,
    ST_DIGIT3    = 4'd2,
    ST_DIGIT4    = 4'd3,
    ST_FETCH_ROM = 4'd4,
    ST_CATCH_ROM = 4'd5,
    ST_COMPARE   = 4'd6,
    ST_MATCHED   = 4'd7,
    ST_NOMATCH   = 4'd8
  } state_t;

endpackage

// File: rtl/id_entry_handler_if.sv
// Bundle of switch/button inputs, ID ROM port and password-stage handshake.
// master: the environment (switches, ROM, password checker); slave: the handler.
interface id_entry_handler_if;
  import id_entry_handler_pkg::*;

  logic [3:0]          IDSwitch;
  logic                IDButton;
  logic                ClearID;
  logic [ADDR_W-1:0]   ROM_Address;
  logic [ID_WIDTH-1:0] ROM_Data;
  logic                MatchedID;
  logic [ADDR_W-1:0]   PlayerAddress_to_PW;
  logic                IDError;
  logic [DCNT_W-1:0]   DigitCount;

  modport master (
    output IDSwitch, IDButton, ClearID, ROM_Data,
    input  ROM_Address, MatchedID, PlayerAddress_to_PW, IDError, DigitCount
  );

  modport slave (
    input  IDSwitch, IDButton, ClearID, ROM_Data,
    output ROM_Address, MatchedID, PlayerAddress_to_PW, IDError, DigitCount
  );

endinterface

// File: rtl/id_entry_handler.sv
// Collects a 4-digit hex ID and scans the ID ROM for a match.
//
// state     | meaning
// ----------+------------------------------------------------
// STANDBY   | waiting for first digit
// DIGIT2    | one digit held, waiting for second
// DIGIT3    | two digits held, waiting for third
// DIGIT4    | three digits held, waiting for fourth
// FETCH_ROM | ROM_Address presented to the synchronous ROM
// CATCH_ROM | ROM word arriving, captured on exit
// COMPARE   | captured word checked against the entered ID
// MATCHED   | ID found, held until ClearID
// NOMATCH   | one-cycle error pulse, then back to STANDBY
module id_entry_handler #(
  parameter int NUM_USERS = id_entry_handler_pkg::NUM_USERS,
  parameter int ID_WIDTH  = id_entry_handler_pkg::ID_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  id_entry_handler_if.slave   bus
);
  import id_entry_handler_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_USERS - 1);

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] entered_id_q, entered_id_d;
  logic [ID_WIDTH-1:0] rom_word_q, rom_word_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]   player_addr_q, player_addr_d;
  logic [DCNT_W-1:0]   digit_cnt_q, digit_cnt_d;

  logic id_hit;
  logic last_entry;

  // An empty slot never matches, so an entered FFFF always scans to NOMATCH.
  assign id_hit     = (rom_word_q == entered_id_q) && (rom_word_q != EMPTY_ID);
  assign last_entry = (rom_addr_q == LAST_ADDR);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_STANDBY;
      entered_id_q  <= '0;
      rom_word_q    <= '0;
      rom_addr_q    <= '0;
      player_addr_q <= '0;
      digit_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      entered_id_q  <= entered_id_d;
      rom_word_q    <= rom_word_d;
      rom_addr_q    <= rom_addr_d;
      player_addr_q <= player_addr_d;
      digit_cnt_q   <= digit_cnt_d;
    end
  end

  // Next-state decode; ClearID overrides every state, including a same-cycle digit.
  always_comb begin
    state_d = state_q;
    if (bus.ClearID) begin
      state_d = ST_STANDBY;
    end else begin
      case (state_q)
        ST_STANDBY:   if (bus.IDButton) state_d = ST_DIGIT2;
        ST_DIGIT2:    if (bus.IDButton) state_d = ST_DIGIT3;
        ST_DIGIT3:    if (bus.IDButton) state_d = ST_DIGIT4;
        ST_DIGIT4:    if (bus.IDButton) state_d = ST_FETCH_ROM;
        ST_FETCH_ROM: state_d = ST_CATCH_ROM;
        ST_CATCH_ROM: state_d = ST_COMPARE;
        ST_COMPARE: begin
          if (id_hit)          state_d = ST_MATCHED;
          else if (last_entry) state_d = ST_NOMATCH;
          else                 state_d = ST_FETCH_ROM;
        end
        ST_MATCHED:   state_d = ST_MATCHED;
        ST_NOMATCH:   state_d = ST_STANDBY;
        default:      state_d = ST_STANDBY;
      endcase
    end
  end

  // Datapath next values: digit shift, ROM capture, address walk, match latch.
  always_comb begin
    entered_id_d  = entered_id_q;
    rom_word_d    = rom_word_q;
    rom_addr_d    = rom_addr_q;
    player_addr_d = player_addr_q;
    digit_cnt_d   = digit_cnt_q;
    if (bus.ClearID) begin
      entered_id_d  = '0;
      rom_addr_d    = '0;
      player_addr_d = '0;
      digit_cnt_d   = '0;
    end else begin
      case (state_q)
        ST_STANDBY, ST_DIGIT2, ST_DIGIT3, ST_DIGIT4: begin
          if (bus.IDButton) begin
            entered_id_d = {entered_id_q[ID_WIDTH-5:0], bus.IDSwitch};
            digit_cnt_d  = digit_cnt_q + 1'b1;
            if (state_q == ST_DIGIT4) rom_addr_d = '0;
          end
        end
        ST_CATCH_ROM: rom_word_d = bus.ROM_Data;
        ST_COMPARE: begin
          if (id_hit)           player_addr_d = rom_addr_q;
          else if (!last_entry) rom_addr_d    = rom_addr_q + 1'b1;
        end
        ST_NOMATCH: begin
          entered_id_d = '0;
          rom_addr_d   = '0;
          digit_cnt_d  = '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs: flags decoded from state, everything else straight from registers.
  always_comb begin
    bus.MatchedID           = (state_q == ST_MATCHED);
    bus.IDError             = (state_q == ST_NOMATCH);
    bus.ROM_Address         = rom_addr_q;
    bus.PlayerAddress_to_PW = player_addr_q;
    bus.DigitCount          = digit_cnt_q;
  end

endmodule

// File: tb/tb_id_entry_handler.sv
// Directed bench for id_entry_handler with a behavioural synchronous ID ROM.
module tb_id_entry_handler;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  logic [15:0] rom_mem [8];

  id_entry_handler_if bus ();

  id_entry_handler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) bus.ROM_Data <= rom_mem[bus.ROM_Address];

  task automatic load_rom_a();
    rom_mem[0] = 16'h1234; rom_mem[1] = 16'h0042; rom_mem[2] = 16'hFFFF;
    rom_mem[3] = 16'h1111; rom_mem[4] = 16'h2222; rom_mem[5] = 16'h3333;
    rom_mem[6] = 16'h4444; rom_mem[7] = 16'h5555;
  endtask

  task automatic load_rom_b();
    rom_mem[0] = 16'h0001; rom_mem[1] = 16'h1000; rom_mem[2] = 16'hA5A5;
    rom_mem[3] = 16'hBEEE; rom_mem[4] = 16'hEBEF; rom_mem[5] = 16'hFEEB;
    rom_mem[6] = 16'h0BEF; rom_mem[7] = 16'hBEEF;
  endtask

  task automatic load_rom_empty();
    for (int i = 0; i < 8; i++) rom_mem[i] = 16'hFFFF;
  endtask

  // Called at a negedge; the digit commits on the following posedge.
  task automatic press(input logic [3:0] d);
    bus.IDSwitch = d;
    bus.IDButton = 1'b1;
    @(negedge clk);
    bus.IDButton = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.ClearID = 1'b1;
    @(negedge clk);
    bus.ClearID = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.MatchedID !== 1'b0) begin n_fail++; $display("FAIL rst_matched: got %0b want 0", bus.MatchedID); end
    n_cmp++; if (bus.IDError !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %0b want 0", bus.IDError); end
    n_cmp++; if (bus.DigitCount !== 3'd0) begin n_fail++; $display("FAIL rst_dcount: got %0d want 0", bus.DigitCount); end
    n_cmp++; if (bus.ROM_Address !== 3'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", bus.ROM_Address); end
    n_cmp++; if (bus.PlayerAddress_to_PW !== 3'd0) begin n_fail++; $display("FAIL rst_pa: got %0d want 0", bus.PlayerAddress_to_PW); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_match_entry0();
    load_rom_a();
    press(4'h1);
    n_cmp++; if (bus.DigitCount !== 3'd1) begin n_fail++; $display("FAIL e0_dcount1: got %0d want 1", bus.DigitCount); end
    press(4'h2);
    n_cmp++; if (bus.DigitCount !== 3'd2) begin n_fail++; $display("FAIL e0_dcount2: got %0d want 2", bus.DigitCount); end
    press(4'h3);
    n_cmp++; if (bus.DigitCount !== 3'd3) begin n_fail++; $display("FAIL e0_dcount3: got %0d want 3", bus.DigitCount); end
    press(4'h4);
    n_cmp++; if (bus.DigitCount !== 3'd4) begin n_fail++; $display("FAIL e0_dcount4: got %0d want 4", bus.DigitCount); end
    n_cmp++; if (bus.ROM_Address !== 3'd0) begin n_fail++; $display("FAIL e0_addr: got %0d want 0", bus.ROM_Address); end
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.MatchedID !== 1'b0) begin n_fail++; $display("FAIL e0_early: got %0b want 0 at E0+2", bus.MatchedID); end
    @(negedge clk);
    n_cmp++; if (bus.MatchedID !== 1'b1) begin n_fail++; $display("FAIL e0_match: got %0b want 1 at E0+3", bus.MatchedID); end
    n_cmp++; if (bus.PlayerAddress_to_PW !== 3'd0) begin n_fail++; $display("FAIL e0_pa: got %0d want 0", bus.PlayerAddress_to_PW); end
    n_cmp++; if (bus.DigitCount !== 3'd4) begin n_fail++; $display("FAIL e0_dcount_m: got %0d want 4", bus.DigitCount); end
  endtask

  task automatic test_matched_hold();
    repeat (3) press(4'hA);
    n_cmp++; if (bus.MatchedID !== 1'b1) begin n_fail++; $display("FAIL hold_matched: got %0b want 1", bus.MatchedID); end
    n_cmp++; if (bus.DigitCount !== 3'd4) begin n_fail++; $display("FAIL hold_dcount: got %0d want 4", bus.DigitCount); end
    n_cmp++; if (bus.PlayerAddress_to_PW !== 3'd0) begin n_fail++; $display("FAIL hold_pa: got %0d want 0", bus.PlayerAddress_to_PW); end
    pulse_clear();
    n_cmp++; if (bus.MatchedID !== 1'b0) begin n_fail++; $display("FAIL clr_matched: got %0b want 0", bus.MatchedID); end
    n_cmp++; if (bus.DigitCount !== 3'd0) begin n_fail++; $display("FAIL clr_dcount: got %0d want 0", bus.DigitCount); end
  endtask

  task automatic test_scan_last_entry();
    load_rom_b();
    press(4'hB); press(4'hE); press(4'hE); press(4'hF);
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 10) begin
        n_cmp++; if (bus.DigitCount !== 3'd4) begin n_fail++; $display("FAIL e7_dcount: got %0d want 4", bus.DigitCount); end
      end
      if (i == 23) begin
        n_cmp++; if (bus.MatchedID !== 1'b0) begin n_fail++; $display("FAIL e7_early: got %0b want 0 at E0+23", bus.MatchedID); end
        n_cmp++; if (bus.ROM_Address !== 3'd7) begin n_fail++; $display("FAIL e7_addr: got %0d want 7", bus.ROM_Address); end
      end
      if (i == 24) begin
        n_cmp++; if (bus.MatchedID !== 1'b1) begin n_fail++; $display("FAIL e7_match: got %0b want 1 at E0+24", bus.MatchedID); end
        n_cmp++; if (bus.PlayerAddress_to_PW !== 3'd7) begin n_fail++; $display("FAIL e7_pa: got %0d want 7", bus.PlayerAddress_to_PW); end
      end
      bus.IDSwitch = 4'h0;
      bus.IDButton = (i == 4) || (i == 13);
    end
    bus.IDButton = 1'b0;
    pulse_clear();
  endtask

  task automatic test_nomatch();
    int err_cnt;
    err_cnt = 0;
    load_rom_b();
    press(4'h9); press(4'h9); press(4'h9); press(4'h9);
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (bus.IDError === 1'b1) err_cnt++;
      if (i == 24) begin
        n_cmp++; if (bus.IDError !== 1'b1) begin n_fail++; $display("FAIL nm_error: got %0b want 1 at E0+24", bus.IDError); end
      end
      if (i == 25) begin
        n_cmp++; if (bus.DigitCount !== 3'd0) begin n_fail++; $display("FAIL nm_dcount: got %0d want 0", bus.DigitCount); end
        n_cmp++; if (bus.ROM_Address !== 3'd0) begin n_fail++; $display("FAIL nm_addr: got %0d want 0", bus.ROM_Address); end
        n_cmp++; if (bus.MatchedID !== 1'b0) begin n_fail++; $display("FAIL nm_matched: got %0b want 0", bus.MatchedID); end
      end
    end
    n_cmp++; if (err_cnt != 1) begin n_fail++; $display("FAIL nm_pulses: got %0d want 1", err_cnt); end
    press(4'h5);
    n_cmp++; if (bus.DigitCount !== 3'd1) begin n_fail++; $display("FAIL nm_standby: got %0d want 1", bus.DigitCount); end
    pulse_clear();
  endtask

  task automatic test_ffff_empty();
    int err_cnt;
    int match_cnt;
    err_cnt   = 0;
    match_cnt = 0;
    load_rom_empty();
    press(4'hF); press(4'hF); press(4'hF); press(4'hF);
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (bus.IDError === 1'b1) err_cnt++;
      if (bus.MatchedID === 1'b1) match_cnt++;
      if (i == 24) begin
        n_cmp++; if (bus.IDError !== 1'b1) begin n_fail++; $display("FAIL ff_error: got %0b want 1 at E0+24", bus.IDError); end
      end
    end
    n_cmp++; if (err_cnt != 1) begin n_fail++; $display("FAIL ff_pulses: got %0d want 1", err_cnt); end
    n_cmp++; if (match_cnt != 0) begin n_fail++; $display("FAIL ff_matched: got %0d cycles want 0", match_cnt); end
  endtask

  task automatic test_clear_collision();
    load_rom_a();
    press(4'h1); press(4'h2);
    n_cmp++; if (bus.DigitCount !== 3'd2) begin n_fail++; $display("FAIL col_pre: got %0d want 2", bus.DigitCount); end
    bus.IDSwitch = 4'h3;
    bus.IDButton = 1'b1;
    bus.ClearID  = 1'b1;
    @(negedge clk);
    bus.IDButton = 1'b0;
    bus.ClearID  = 1'b0;
    n_cmp++; if (bus.DigitCount !== 3'd0) begin n_fail++; $display("FAIL col_dcount: got %0d want 0", bus.DigitCount); end
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.MatchedID !== 1'b1) begin n_fail++; $display("FAIL col_rematch: got %0b want 1", bus.MatchedID); end
    pulse_clear();
  endtask

  task automatic test_async_reset();
    load_rom_b();
    press(4'h9); press(4'h9); press(4'h9); press(4'h9);
    repeat (10) @(negedge clk);
    n_cmp++; if (bus.ROM_Address !== 3'd3) begin n_fail++; $display("FAIL ar_addr_pre: got %0d want 3", bus.ROM_Address); end
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (bus.ROM_Address !== 3'd0) begin n_fail++; $display("FAIL ar_addr: got %0d want 0", bus.ROM_Address); end
    n_cmp++; if (bus.DigitCount !== 3'd0) begin n_fail++; $display("FAIL ar_dcount: got %0d want 0", bus.DigitCount); end
    n_cmp++; if (bus.MatchedID !== 1'b0) begin n_fail++; $display("FAIL ar_matched: got %0b want 0", bus.MatchedID); end
    n_cmp++; if (bus.IDError !== 1'b0) begin n_fail++; $display("FAIL ar_error: got %0b want 0", bus.IDError); end
    n_cmp++; if (bus.PlayerAddress_to_PW !== 3'd0) begin n_fail++; $display("FAIL ar_pa: got %0d want 0", bus.PlayerAddress_to_PW); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    press(4'h7);
    n_cmp++; if (bus.DigitCount !== 3'd1) begin n_fail++; $display("FAIL ar_standby: got %0d want 1", bus.DigitCount); end
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    bus.IDSwitch = 4'h0;
    bus.IDButton = 1'b0;
    bus.ClearID  = 1'b0;
    load_rom_a();
    rst = 1'b1;
    #1 rst = 1'b0;
    test_reset();
    test_match_entry0();
    test_matched_hold();
    test_scan_last_entry();
    test_nomatch();
    test_ffff_empty();
    test_clear_collision();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
